// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL-lock driven multi-channel staggered reset sequencer
module reset_sequencer #(
    parameter int CHANNELS       = 4,
    parameter int HOLD_CYCLES    = 63,
    parameter int STAGGER_CYCLES = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                iLocked,
    input  logic                iSoftReset,
    output logic [CHANNELS-1:0] oReset,
    output logic                oRunning,
    output logic [1:0]          oState,
    output logic [7:0]          oLockLossCount
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int HW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int REL_LAST = (CHANNELS - 1) * STAGGER_CYCLES;
    localparam int SW       = (REL_LAST > 1) ? $clog2(REL_LAST + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STAG_LAST = SW'(REL_LAST);

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic                   lock_s, lock_d, abort;
    logic [HW-1:0]          hold_cnt, hold_nx;
    logic [SW-1:0]          stag_cnt, stag_nx, stag_inc;
    logic [CHANNELS-1:0]    rst_q, rst_nx;
    logic                   run_q, run_nx;
    logic [7:0]             loss_cnt;

    assign lock_s   = sync[SYNC_STAGES-1];
    assign abort    = !lock_s || iSoftReset;
    assign stag_inc = stag_cnt + 1'b1;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= WAIT_LOCK;
            sync     <= '0;
            lock_d   <= 1'b0;
            hold_cnt <= '0;
            stag_cnt <= '0;
            rst_q    <= '1;
            run_q    <= 1'b0;
            loss_cnt <= '0;
        end else begin
            state    <= state_nx;
            sync     <= {sync[SYNC_STAGES-2:0], iLocked};
            lock_d   <= lock_s;
            hold_cnt <= hold_nx;
            stag_cnt <= stag_nx;
            rst_q    <= rst_nx;
            run_q    <= run_nx;
            // Falling edge of the synchronised lock, counted in every state
            if (lock_d && !lock_s && loss_cnt != 8'hFF)
                loss_cnt <= loss_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT_LOCK: if (lock_s && !iSoftReset) state_nx = HOLD;
            HOLD: begin
                if (abort)
                    state_nx = WAIT_LOCK;
                else if (hold_cnt == HOLD_LAST)
                    state_nx = (CHANNELS == 1) ? RUN : RELEASE;
            end
            RELEASE: begin
                if (abort)
                    state_nx = WAIT_LOCK;
                else if (stag_inc == STAG_LAST)
                    state_nx = RUN;
            end
            RUN: if (abort) state_nx = WAIT_LOCK;
            default: state_nx = WAIT_LOCK;
        endcase
    end

    always_comb begin
        hold_nx = '0;
        stag_nx = stag_cnt;
        rst_nx  = rst_q;
        run_nx  = run_q;
        if (state != WAIT_LOCK && abort) begin
            rst_nx  = '1;
            run_nx  = 1'b0;
            stag_nx = '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    rst_nx  = '1;
                    run_nx  = 1'b0;
                    stag_nx = '0;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        rst_nx[0] = 1'b0;
                        stag_nx   = '0;
                        run_nx    = (CHANNELS == 1);
                    end else begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    stag_nx = stag_inc;
                    // Channel k drops k*STAGGER_CYCLES edges after RELEASE entry
                    for (int k = 1; k < CHANNELS; k++)
                        if (stag_inc == SW'(k * STAGGER_CYCLES))
                            rst_nx[k] = 1'b0;
                    if (stag_inc == STAG_LAST)
                        run_nx = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign oReset         = rst_q;
    assign oRunning       = run_q;
    assign oState         = state;
    assign oLockLossCount = loss_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized bench for reset_sequencer with timeline model
module tb_reset_sequencer;

    localparam int C    = 4;
    localparam int HOLD = 8;
    localparam int STAG = 4;
    localparam int SYNC = 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iLocked = 1'b1;
    logic       iSoftReset = 1'b0;
    logic [3:0] oReset;
    logic       oRunning;
    logic [1:0] oState;
    logic [7:0] oLockLossCount;
    logic [0:0] oReset1;
    logic       oRunning1;
    logic [1:0] oState1;
    logic [7:0] oLockLossCount1;

    int n_chk  = 0;
    int n_fail = 0;

    reset_sequencer #(.CHANNELS(C), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .SYNC_STAGES(SYNC)) dut (
        .Clock(Clock), .Reset(Reset), .iLocked(iLocked), .iSoftReset(iSoftReset),
        .oReset(oReset), .oRunning(oRunning), .oState(oState), .oLockLossCount(oLockLossCount)
    );

    reset_sequencer #(.CHANNELS(1), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .SYNC_STAGES(SYNC)) dut1 (
        .Clock(Clock), .Reset(Reset), .iLocked(iLocked), .iSoftReset(iSoftReset),
        .oReset(oReset1), .oRunning(oRunning1), .oState(oState1), .oLockLossCount(oLockLossCount1)
    );

    always #5 Clock = ~Clock;

    // Model: t = edges since HOLD entry (-1 when waiting); outputs follow arithmetically from t
    logic [SYNC-1:0] m_sync = '0;
    logic            m_prev = 1'b0;
    int              m_loss = 0;
    int              m_t[2] = '{-1, -1};

    function automatic int chans(int i);
        return (i == 0) ? C : 1;
    endfunction

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            m_sync <= '0;
            m_prev <= 1'b0;
            m_loss <= 0;
            m_t    <= '{-1, -1};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_t[i] < 0)
                    m_t[i] <= (m_sync[SYNC-1] && !iSoftReset) ? 0 : -1;
                else if (!m_sync[SYNC-1] || iSoftReset)
                    m_t[i] <= -1;
                else if (m_t[i] < HOLD + (chans(i) - 1) * STAG)
                    m_t[i] <= m_t[i] + 1;
            end
            if (m_prev && !m_sync[SYNC-1] && m_loss < 255)
                m_loss <= m_loss + 1;
            m_prev <= m_sync[SYNC-1];
            m_sync <= {m_sync[SYNC-2:0], iLocked};
        end
    end

    function automatic logic [1:0] e_state(int t, int ch);
        if (t < 0) return 2'd0;
        if (t < HOLD) return 2'd1;
        if (t < HOLD + (ch - 1) * STAG) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [3:0] e_rst(int t, int ch);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < ch; k++)
            r[k] = (t < 0) || (t < HOLD + k * STAG);
        return r;
    endfunction

    function automatic logic e_run(int t, int ch);
        return (t >= HOLD + (ch - 1) * STAG);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        logic [3:0] r1;
        r1 = e_rst(m_t[1], 1);
        chk("model_oReset",    32'(oReset),         32'(e_rst(m_t[0], C)));
        chk("model_oRunning",  32'(oRunning),       32'(e_run(m_t[0], C)));
        chk("model_oState",    32'(oState),         32'(e_state(m_t[0], C)));
        chk("model_count",     32'(oLockLossCount), 32'(m_loss));
        chk("model1_oReset",   32'(oReset1),        32'(r1[0]));
        chk("model1_oRunning", 32'(oRunning1),      32'(e_run(m_t[1], 1)));
        chk("model1_oState",   32'(oState1),        32'(e_state(m_t[1], 1)));
        chk("model1_count",    32'(oLockLossCount1), 32'(m_loss));
    end

    task automatic adv(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic rst_pulse();
        @(negedge Clock);
        Reset = 1'b0;
        adv(2);
        chk("rst_oReset", 32'(oReset), 32'hF);
        chk("rst_oRunning", 32'(oRunning), 32'd0);
        chk("rst_oState", 32'(oState), 32'd0);
        chk("rst_count", 32'(oLockLossCount), 32'd0);
        Reset = 1'b1;
    endtask

    // Walk a sequence whose HOLD entry is pre edges away
    task automatic seq_check(input int pre, input bit full);
        adv(pre);
        chk("seq_hold_state", 32'(oState), 32'd1);
        chk("seq_hold_rst", 32'(oReset), 32'hF);
        adv(HOLD - 1);
        chk("seq_prerel_rst", 32'(oReset), 32'hF);
        chk("seq_prerel_rst1", 32'(oReset1), 32'd1);
        chk("seq_prerel_run1", 32'(oRunning1), 32'd0);
        adv(1);
        chk("seq_rel0_rst", 32'(oReset), 32'hE);
        chk("seq_rel0_state", 32'(oState), 32'd2);
        chk("seq_c1_rst", 32'(oReset1), 32'd0);
        chk("seq_c1_run", 32'(oRunning1), 32'd1);
        chk("seq_c1_state", 32'(oState1), 32'd3);
        adv(STAG);
        chk("seq_rel1_rst", 32'(oReset), 32'hC);
        if (full) begin
            adv(2 * STAG - 1);
            chk("seq_prerun_rst", 32'(oReset), 32'h8);
            chk("seq_prerun_run", 32'(oRunning), 32'd0);
            adv(1);
            chk("seq_run_rst", 32'(oReset), 32'h0);
            chk("seq_run_run", 32'(oRunning), 32'd1);
            chk("seq_run_state", 32'(oState), 32'd3);
        end
    endtask

    initial begin
        adv(2);
        chk("init_oReset", 32'(oReset), 32'hF);
        chk("init_state", 32'(oState), 32'd0);
        Reset = 1'b1;

        // Cold start
        seq_check(3, 1'b1);

        // Lock loss in RUN
        adv(7);
        iLocked = 1'b0;
        adv(2);
        chk("loss_still_run", 32'(oRunning), 32'd1);
        adv(1);
        chk("loss_rst", 32'(oReset), 32'hF);
        chk("loss_run", 32'(oRunning), 32'd0);
        chk("loss_state", 32'(oState), 32'd0);
        chk("loss_count", 32'(oLockLossCount), 32'd1);
        adv(2);
        iLocked = 1'b1;
        seq_check(3, 1'b0);

        // Soft reset mid-RELEASE
        iSoftReset = 1'b1;
        adv(1);
        chk("soft_rst", 32'(oReset), 32'hF);
        chk("soft_state", 32'(oState), 32'd0);
        chk("soft_count", 32'(oLockLossCount), 32'd1);
        adv(4);
        chk("soft_held_state", 32'(oState), 32'd0);
        iSoftReset = 1'b0;
        seq_check(1, 1'b1);

        // Late lock
        iLocked = 1'b0;
        rst_pulse();
        adv(20);
        chk("late_wait_state", 32'(oState), 32'd0);
        chk("late_wait_rst", 32'(oReset), 32'hF);
        iLocked = 1'b1;
        seq_check(3, 1'b1);

        // Random lock drops and soft resets
        for (int s = 0; s < 300; s++) begin
            iLocked    = ($urandom_range(0, 99) < 85);
            iSoftReset = ($urandom_range(0, 99) < 8);
            adv($urandom_range(1, 30));
        end

        // Async reset mid-HOLD, between edges
        iSoftReset = 1'b0;
        iLocked    = 1'b1;
        for (int i = 0; i < 200 && !(m_t[0] >= 1 && m_t[0] < HOLD - 1); i++)
            adv(1);
        chk("reach_hold", 32'(m_t[0] >= 1 && m_t[0] < HOLD - 1), 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("async_rst", 32'(oReset), 32'hF);
        chk("async_run", 32'(oRunning), 32'd0);
        chk("async_state", 32'(oState), 32'd0);
        chk("async_count", 32'(oLockLossCount), 32'd0);
        chk("async_rst1", 32'(oReset1), 32'd1);
        adv(1);
        Reset = 1'b1;

        // Saturation
        for (int d = 0; d < 300; d++) begin
            iLocked = 1'b0;
            adv(3);
            iLocked = 1'b1;
            adv(3);
        end
        chk("sat_count", 32'(oLockLossCount), 32'd255);
        chk("sat_count1", 32'(oLockLossCount1), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
